// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: branch opcodes,
// the resolver FSM state type and a small opcode decode helper.
package branch_pkg;

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True for the two conditional branch opcodes handled in ID.
   function automatic logic is_branch_op(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/branch_target_add.sv
// Branch target adder: plain 32-bit sum, wraps modulo 2^32, no carry out.
module branch_target_add (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_sum
);

   // Carry out is intentionally discarded so the target wraps.
   assign o_sum = i_a + i_b;

endmodule

// File: rtl/branch_resolve.sv
// ID-stage branch resolver for BEQ/BNE. Waits (stalling IF/ID) for
// forwarded operands, resolves the branch, then raises a one-cycle
// pc_src/if_flush pulse for taken branches. A wait that runs past
// MAX_WAIT cycles gives up and sets the sticky wait_err flag.
//
// Handshake: id_valid qualifies the ID-stage instruction every cycle.
// While stall is 1 the upstream pipeline must hold id_* inputs steady;
// dropping id_valid while waiting abandons the branch. The instruction is
// consumed (resolved) in the cycle where it is a branch, id_valid=1 and both
// operand ready flags are 1 with no stall asserted.
module branch_resolve
   import branch_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [31:0]      pc_plus4,
   input  logic [31:0]      offset_sh,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   input  logic             rs_ready,
   input  logic             rt_ready,
   output logic             stall,
   output logic             pc_src,
   output logic [31:0]      branch_target,
   output logic             if_flush,
   output logic [CNT_W-1:0] taken_count,
   output logic             wait_err,
   output logic [1:0]       dbg_state
);

   localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] MAX_CNT = WCW'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

   state_t           r_state;
   logic [WCW-1:0]   r_wait_cnt;
   logic [31:0]      r_target;
   logic             r_pc_src;
   logic             r_if_flush;
   logic [CNT_W-1:0] r_taken_count;
   logic             r_wait_err;

   logic        w_is_branch;
   logic        w_ready;
   logic        w_equal;
   logic        w_taken;
   logic        w_cnt_max;
   logic        w_resolve;
   logic        w_stall;
   logic [31:0] w_target;

   branch_target_add u_target_add (
      .i_a   (pc_plus4),
      .i_b   (offset_sh),
      .o_sum (w_target)
   );

   assign w_is_branch = id_valid & is_branch_op(id_opcode);
   assign w_ready     = rs_ready & rt_ready;
   assign w_equal     = (rs_data == rt_data);
   assign w_taken     = (id_opcode == OP_BEQ) ? w_equal : ~w_equal;
   assign w_cnt_max   = (r_wait_cnt == MAX_CNT);
   // A branch resolves in IDLE or WAIT once both operands are ready.
   assign w_resolve   = ((r_state == ST_IDLE) & w_is_branch & w_ready) |
                        ((r_state == ST_WAIT) & id_valid & w_ready);

   // Stall while a branch is waiting on operands; released on the give-up
   // cycle, on abort and during reset.
   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         ST_IDLE: w_stall = w_is_branch & ~w_ready;
         ST_WAIT: w_stall = id_valid & ~w_ready & ~w_cnt_max;
         default: w_stall = 1'b0;
      endcase
      if (!rst_n) w_stall = 1'b0;
   end

   // Resolver FSM with its registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_wait_cnt    <= '0;
         r_target      <= '0;
         r_pc_src      <= 1'b0;
         r_if_flush    <= 1'b0;
         r_taken_count <= '0;
         r_wait_err    <= 1'b0;
      end else begin
         r_pc_src   <= 1'b0;
         r_if_flush <= 1'b0;
         if (w_resolve) begin
            r_target   <= w_target;
            r_pc_src   <= w_taken;
            r_if_flush <= w_taken;
            if (w_taken && (r_taken_count != CNT_SAT))
               r_taken_count <= r_taken_count + CNT_W'(1);
         end
         case (r_state)
            ST_IDLE: begin
               if (w_is_branch) begin
                  if (w_ready) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_state    <= ST_WAIT;
                     r_wait_cnt <= '0;
                  end
               end
            end
            ST_WAIT: begin
               if (!id_valid) begin
                  r_state <= ST_IDLE;
               end else if (w_ready) begin
                  r_state <= ST_DONE;
               end else if (w_cnt_max) begin
                  r_wait_err <= 1'b1;
                  r_state    <= ST_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WCW'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign stall         = w_stall;
   assign pc_src        = r_pc_src;
   assign if_flush      = r_if_flush;
   assign branch_target = r_target;
   assign taken_count   = r_taken_count;
   assign wait_err      = r_wait_err;
   assign dbg_state     = r_state;

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter CNT_W, default 16, width of the taken-branch counter.
REQ-002 Parameter MAX_WAIT, default 3, maximum operand-wait cycles before error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_valid  input  1  ID-stage instruction valid.
REQ-006 id_opcode  input  6  ID-stage opcode; 6'b000100 = BEQ, 6'b000101 = BNE.
REQ-007 pc_plus4  input  32  PC+4 of the ID-stage instruction.
REQ-008 offset_sh  input  32  sign-extended immediate already shifted left by 2.
REQ-009 rs_data, rt_data  input  32 each  register operands (post-forwarding).
REQ-010 rs_ready, rt_ready  input  1 each  operand valid, no producer pending in EX/MEM.
REQ-011 stall  output  1  freeze PC and IF/ID register.
REQ-012 pc_src  output  1  select branch_target as next PC.
REQ-013 branch_target  output  32  registered branch target address.
REQ-014 if_flush  output  1  squash the instruction in IF/ID.
REQ-015 taken_count  output  CNT_W  number of taken branches since reset.
REQ-016 wait_err  output  1  sticky: operand wait exceeded MAX_WAIT.

Function
REQ-017 The block SHALL treat only BEQ/BNE with id_valid=1 as branches; other opcodes cause no state change and no output activity.
REQ-018 FSM states SHALL be IDLE, WAIT, DONE.
REQ-019 IDLE: branch with rs_ready&rt_ready SHALL latch decision and target, go to DONE; branch with either not ready SHALL go to WAIT, clear wait counter.
REQ-020 stall SHALL be combinationally 1 in IDLE when a branch is present with an operand not ready, and 1 throughout WAIT; 0 otherwise.
REQ-021 WAIT: when both ready SHALL latch decision and target, go to DONE; otherwise increment wait counter.
REQ-022 WAIT: when wait counter reaches MAX_WAIT with operands still not ready, SHALL set wait_err, drop stall, return to IDLE without resolving.
REQ-023 WAIT: id_valid=0 SHALL abort to IDLE with no resolution and no counter update.
REQ-024 Decision: taken = (rs_data==rt_data) for BEQ, (rs_data!=rt_data) for BNE, sampled in the resolving cycle.
REQ-025 branch_target SHALL be pc_plus4 + offset_sh, modulo 2^32 (wrap, no overflow flag).
REQ-026 DONE lasts exactly one cycle: pc_src = if_flush = taken; then IDLE.
REQ-027 Latency: resolving cycle to pc_src/if_flush = 1 clock.
REQ-028 In DONE, ID inputs SHALL be ignored (instruction is being flushed or re-presented).
REQ-029 taken_count SHALL increment by 1 per taken resolution and saturate at all-ones.
REQ-030 branch_target SHALL hold its last value outside DONE.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, wait counter 0, stall 0, pc_src 0, if_flush 0, branch_target 0, taken_count 0, wait_err 0.
REQ-032 Reset asserted mid-WAIT or in DONE SHALL drop any pending resolution; no pulse after release.
REQ-033 First resolution after rst_n release SHALL be possible on the first rising edge.

Structure
REQ-034 Shared package branch_pkg SHALL hold OP_BEQ, OP_BNE constants and the FSM state type.
REQ-035 Target adder SHALL be a sub-module branch_target_add (32-bit a+b, combinational); comparator and FSM stay in branch_resolve.

Verification
REQ-036 BEQ, rs=rt=0x5, ready, pc_plus4=0x00400004, offset_sh=0x10 -> next cycle pc_src=1, if_flush=1, target 0x00400014, taken_count=1.
REQ-037 BNE, rs=rt=0x7, ready -> stall never 1, pc_src=0, if_flush=0, taken_count unchanged.
REQ-038 BEQ rs_ready=0 for 2 cycles then 1, rs=rt -> stall=1 for exactly 2 cycles, then pc_src pulse 1 cycle later.
REQ-039 BEQ with rt_ready held 0 (MAX_WAIT=3) -> stall 1 for 4 cycles, wait_err=1, no pc_src pulse.
REQ-040 pc_plus4=0xFFFFFFFC, offset_sh=0x8, taken -> target 0x00000004; rst_n pulsed low during WAIT -> all outputs 0 immediately, no pulse after release.
